// File: rtl/io_arb_pkg.sv
// Shared types and constants for the MMIO bus arbiter.
//   arb_state_t : arbiter FSM states
//   BUS_AW/BUS_DW : I/O bus address and data widths
//   MAX_NUM_REQ : largest supported requester count
//   CNT_W : width of the read-latency wait counter
package io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int BUS_AW         = 32;
  localparam int BUS_DW         = 32;
  localparam int MAX_NUM_REQ    = 8;
  localparam int MAX_RD_LATENCY = 3;
  localparam int CNT_W          = 2;

endpackage

// File: rtl/io_bus_arbiter_rr.sv
// Combinational rotating-priority picker.
//   req     : request vector
//   last_id : index of the most recent grant
//   any_req : at least one request is pending
//   next_id : first requester at or after last_id+1 (wrapping) with req set;
//             equals last_id when nothing is pending
module rr_arbiter
  import io_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic               any_req,
  output logic [ID_W-1:0]    next_id
);

  logic            found;
  logic [ID_W-1:0] idx;

  // Walk the candidates in priority order; the last grant comes last, so a
  // lone requester can still be served repeatedly.
  always_comb begin
    any_req = |req;
    next_id = last_id;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(last_id) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        next_id = idx;
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the single MMIO I/O bus between NUM_REQ masters.
// One bus transaction per grant; read data is captured RD_LATENCY cycles
// after the issue cycle and returned with a one-cycle per-requester ack.
//   clk, reset             : clock, synchronous active-high reset
//   req_valid/req_wr       : per-requester request and direction (1 = write)
//   req_addr/req_wr_data   : per-requester address and write data
//   req_ack                : one-hot completion pulse
//   rsp_rd_data            : read data, valid with req_ack
//   busy                   : FSM not idle
//   grant_id               : requester currently or last served
//   bus_cs/bus_wr/bus_rd   : I/O bus strobes (one cs cycle per transaction)
//   bus_addr/bus_wr_data   : I/O bus address and write data
//   bus_rd_data            : I/O bus read data from the slot mux
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int RD_LATENCY = 1,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_wr,
  input  logic [NUM_REQ-1:0][BUS_AW-1:0] req_addr,
  input  logic [NUM_REQ-1:0][BUS_DW-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [BUS_DW-1:0]              rsp_rd_data,
  output logic                           busy,
  output logic [ID_W-1:0]                grant_id,
  output logic                           bus_cs,
  output logic                           bus_wr,
  output logic                           bus_rd,
  output logic [BUS_AW-1:0]              bus_addr,
  output logic [BUS_DW-1:0]              bus_wr_data,
  input  logic [BUS_DW-1:0]              bus_rd_data
);

  localparam int RD_LAT_M1 = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             wr_q;
  logic [CNT_W-1:0] cnt;
  logic             any_req;
  logic [ID_W-1:0]  pick_id;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req    (req_valid),
    .last_id(grant_id),
    .any_req(any_req),
    .next_id(pick_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes and ack are decoded from state, so a reset drops them on the
  // very next cycle without any extra clearing logic.
  always_comb begin
    state_nxt = state;
    bus_cs    = 1'b0;
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;
    req_ack   = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        bus_cs = 1'b1;
        bus_wr = wr_q;
        bus_rd = !wr_q;
        if (wr_q || RD_LATENCY == 0) state_nxt = DONE;
        else                         state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        req_ack[grant_id] = 1'b1;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant: latch the winner's fields. bus_addr is deliberately held through
  // WAIT and IDLE so the slot read mux keeps its selection.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q        <= 1'b0;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      rsp_rd_data <= '0;
      grant_id    <= ID_W'(NUM_REQ - 1);
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            wr_q        <= req_wr[pick_id];
            bus_addr    <= req_addr[pick_id];
            bus_wr_data <= req_wr_data[pick_id];
            grant_id    <= pick_id;
          end
        end
        ISSUE: begin
          if (!wr_q) begin
            if (RD_LATENCY == 0) rsp_rd_data <= bus_rd_data;
            else                 cnt         <= CNT_W'(RD_LAT_M1);
          end
        end
        WAIT: begin
          if (cnt == '0) rsp_rd_data <= bus_rd_data;
          else           cnt         <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
module tb_io_bus_arbiter;

  logic             clk;
  logic             reset;

  logic [1:0]       req_valid, req_wr;
  logic [1:0][31:0] req_addr, req_wr_data;
  logic [1:0]       req_ack;
  logic [31:0]      rsp_rd_data;
  logic             busy;
  logic [0:0]       grant_id;
  logic             bus_cs, bus_wr, bus_rd;
  logic [31:0]      bus_addr, bus_wr_data, bus_rd_data;

  logic [1:0]       r0_req_valid, r0_req_wr;
  logic [1:0][31:0] r0_req_addr, r0_req_wr_data;
  logic [1:0]       r0_req_ack;
  logic [31:0]      r0_rsp_rd_data;
  logic             r0_busy;
  logic [0:0]       r0_grant_id;
  logic             r0_bus_cs, r0_bus_wr, r0_bus_rd;
  logic [31:0]      r0_bus_addr, r0_bus_wr_data, r0_bus_rd_data;

  int checks;
  int errors;

  io_bus_arbiter #(.NUM_REQ(2), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .req_ack(req_ack), .rsp_rd_data(rsp_rd_data),
    .busy(busy), .grant_id(grant_id),
    .bus_cs(bus_cs), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data)
  );

  io_bus_arbiter #(.NUM_REQ(2), .RD_LATENCY(0)) dut_lat0 (
    .clk(clk), .reset(reset),
    .req_valid(r0_req_valid), .req_wr(r0_req_wr),
    .req_addr(r0_req_addr), .req_wr_data(r0_req_wr_data),
    .req_ack(r0_req_ack), .rsp_rd_data(r0_rsp_rd_data),
    .busy(r0_busy), .grant_id(r0_grant_id),
    .bus_cs(r0_bus_cs), .bus_wr(r0_bus_wr), .bus_rd(r0_bus_rd),
    .bus_addr(r0_bus_addr), .bus_wr_data(r0_bus_wr_data),
    .bus_rd_data(r0_bus_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({bus_cs, bus_wr, bus_rd} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b want 000", {bus_cs, bus_wr, bus_rd});
    end
    checks++;
    if ({bus_addr, bus_wr_data, rsp_rd_data} !== 96'd0) begin
      errors++; $display("FAIL reset_data: got addr=%h wd=%h rd=%h want 0", bus_addr, bus_wr_data, rsp_rd_data);
    end
    checks++;
    if ({req_ack, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ack_busy: got ack=%b busy=%b want 00/0", req_ack, busy);
    end
    checks++;
    if (grant_id !== 1'b1) begin
      errors++; $display("FAIL reset_grant_id: got %0d want 1", grant_id);
    end
    checks++;
    if ({r0_busy, r0_grant_id, r0_bus_cs, r0_req_ack} !== 5'b01000) begin
      errors++; $display("FAIL reset_lat0: got busy=%b gid=%b cs=%b ack=%b want 0 1 0 00",
                         r0_busy, r0_grant_id, r0_bus_cs, r0_req_ack);
    end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single_write();
    req_valid[0]   = 1'b1;
    req_wr[0]      = 1'b1;
    req_addr[0]    = 32'h0000_0184;
    req_wr_data[0] = 32'hDEAD_BEEF;
    step();
    checks++;
    if ({bus_cs, bus_wr, bus_rd} !== 3'b110) begin
      errors++; $display("FAIL wr_issue_strobes: got %b want 110", {bus_cs, bus_wr, bus_rd});
    end
    checks++;
    if (bus_addr !== 32'h0000_0184 || bus_wr_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_issue_bus: got addr=%h wd=%h want 00000184 deadbeef", bus_addr, bus_wr_data);
    end
    checks++;
    if (req_ack !== 2'b00 || busy !== 1'b1 || grant_id !== 1'b0) begin
      errors++; $display("FAIL wr_issue_ctrl: got ack=%b busy=%b gid=%0d want 00 1 0", req_ack, busy, grant_id);
    end
    step();
    checks++;
    if (req_ack !== 2'b01 || bus_cs !== 1'b0) begin
      errors++; $display("FAIL wr_done_ack: got ack=%b cs=%b want 01 0", req_ack, bus_cs);
    end
    req_valid[0] = 1'b0;
    step();
    checks++;
    if (req_ack !== 2'b00 || busy !== 1'b0 || bus_addr !== 32'h0000_0184) begin
      errors++; $display("FAIL wr_after_idle: got ack=%b busy=%b addr=%h want 00 0 00000184", req_ack, busy, bus_addr);
    end
  endtask

  task automatic test_read_lat1();
    bus_rd_data  = 32'hBAD0_BAD0;
    req_valid[1] = 1'b1;
    req_wr[1]    = 1'b0;
    req_addr[1]  = 32'h0000_0200;
    step();
    checks++;
    if ({bus_cs, bus_wr, bus_rd} !== 3'b101 || bus_addr !== 32'h0000_0200 || grant_id !== 1'b1) begin
      errors++; $display("FAIL rd_issue: got strobes=%b addr=%h gid=%0d want 101 00000200 1",
                         {bus_cs, bus_wr, bus_rd}, bus_addr, grant_id);
    end
    step();
    bus_rd_data = 32'h1234_5678;
    checks++;
    if ({bus_cs, bus_wr, bus_rd} !== 3'b000 || bus_addr !== 32'h0000_0200 || req_ack !== 2'b00) begin
      errors++; $display("FAIL rd_wait: got strobes=%b addr=%h ack=%b want 000 00000200 00",
                         {bus_cs, bus_wr, bus_rd}, bus_addr, req_ack);
    end
    step();
    checks++;
    if (req_ack !== 2'b10 || rsp_rd_data !== 32'h1234_5678) begin
      errors++; $display("FAIL rd_done: got ack=%b data=%h want 10 12345678", req_ack, rsp_rd_data);
    end
    req_valid[1] = 1'b0;
    bus_rd_data  = 32'hBAD0_BAD0;
    step();
    checks++;
    if (req_ack !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL rd_after_idle: got ack=%b busy=%b want 00 0", req_ack, busy);
    end
  endtask

  task automatic test_contention();
    int acks;
    int cs_cycles;
    logic [31:0] exp_wd;
    acks      = 0;
    cs_cycles = 0;
    req_wr         = 2'b11;
    req_addr[0]    = 32'h0000_0010;
    req_addr[1]    = 32'h0000_0014;
    req_wr_data[0] = 32'h0000_AAAA;
    req_wr_data[1] = 32'h0000_BBBB;
    req_valid      = 2'b11;
    for (int cyc = 0; cyc < 40 && acks < 6; cyc++) begin
      step();
      if (bus_cs === 1'b1) begin
        cs_cycles++;
        exp_wd = (grant_id == 1'b0) ? 32'h0000_AAAA : 32'h0000_BBBB;
        checks++;
        if (bus_wr_data !== exp_wd || bus_rd !== 1'b0 || bus_wr !== 1'b1) begin
          errors++; $display("FAIL cont_bus: got wd=%h wr=%b rd=%b want %h 1 0", bus_wr_data, bus_wr, bus_rd, exp_wd);
        end
      end
      if (req_ack !== 2'b00) begin
        checks++;
        if (req_ack !== ((acks % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL cont_order: ack #%0d got %b want %b", acks, req_ack,
                             (acks % 2 == 0) ? 2'b01 : 2'b10);
        end
        acks++;
        if (acks == 6) req_valid = 2'b00;
      end
    end
    checks++;
    if (acks != 6) begin
      errors++; $display("FAIL cont_ack_count: got %0d want 6", acks);
    end
    checks++;
    if (cs_cycles != 6) begin
      errors++; $display("FAIL cont_cs_cycles: got %0d want 6", cs_cycles);
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0 || grant_id !== 1'b1) begin
      errors++; $display("FAIL cont_end: got busy=%b gid=%0d want 0 1", busy, grant_id);
    end
  endtask

  task automatic test_late_arrival();
    req_valid[0] = 1'b1;
    req_wr[0]    = 1'b0;
    req_addr[0]  = 32'h0000_0300;
    step();
    checks++;
    if (bus_rd !== 1'b1 || grant_id !== 1'b0) begin
      errors++; $display("FAIL late_issue0: got rd=%b gid=%0d want 1 0", bus_rd, grant_id);
    end
    step();
    bus_rd_data    = 32'hA5A5_0001;
    req_valid[1]   = 1'b1;
    req_wr[1]      = 1'b1;
    req_addr[1]    = 32'h0000_0304;
    req_wr_data[1] = 32'h1111_2222;
    step();
    checks++;
    if (req_ack !== 2'b01 || rsp_rd_data !== 32'hA5A5_0001) begin
      errors++; $display("FAIL late_done0: got ack=%b data=%h want 01 a5a50001", req_ack, rsp_rd_data);
    end
    req_valid[0] = 1'b0;
    bus_rd_data  = 32'hBAD0_BAD0;
    step();
    checks++;
    if (busy !== 1'b0 || req_ack !== 2'b00) begin
      errors++; $display("FAIL late_idle: got busy=%b ack=%b want 0 00", busy, req_ack);
    end
    step();
    checks++;
    if (bus_cs !== 1'b1 || bus_wr !== 1'b1 || grant_id !== 1'b1 ||
        bus_addr !== 32'h0000_0304 || bus_wr_data !== 32'h1111_2222) begin
      errors++; $display("FAIL late_issue1: got cs=%b wr=%b gid=%0d addr=%h wd=%h want 1 1 1 00000304 11112222",
                         bus_cs, bus_wr, grant_id, bus_addr, bus_wr_data);
    end
    step();
    checks++;
    if (req_ack !== 2'b10 || rsp_rd_data !== 32'hA5A5_0001) begin
      errors++; $display("FAIL late_done1: got ack=%b data=%h want 10 a5a50001", req_ack, rsp_rd_data);
    end
    req_valid[1] = 1'b0;
    step();
  endtask

  task automatic test_reset_in_wait();
    req_valid[0] = 1'b1;
    req_wr[0]    = 1'b0;
    req_addr[0]  = 32'h0000_0400;
    step();
    step();
    checks++;
    if (busy !== 1'b1 || bus_cs !== 1'b0 || bus_addr !== 32'h0000_0400) begin
      errors++; $display("FAIL rst_pre_wait: got busy=%b cs=%b addr=%h want 1 0 00000400", busy, bus_cs, bus_addr);
    end
    reset        = 1'b1;
    req_valid[0] = 1'b0;
    bus_rd_data  = 32'h7777_7777;
    step();
    reset = 1'b0;
    checks++;
    if ({bus_cs, bus_wr, bus_rd, busy, req_ack} !== 6'b000000 || grant_id !== 1'b1) begin
      errors++; $display("FAIL rst_ctrl: got strobes=%b busy=%b ack=%b gid=%0d want 000 0 00 1",
                         {bus_cs, bus_wr, bus_rd}, busy, req_ack, grant_id);
    end
    checks++;
    if ({bus_addr, bus_wr_data, rsp_rd_data} !== 96'd0) begin
      errors++; $display("FAIL rst_data: got addr=%h wd=%h rd=%h want 0", bus_addr, bus_wr_data, rsp_rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (req_ack !== 2'b00 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_no_ack: cycle %0d got ack=%b busy=%b want 00 0", i, req_ack, busy);
      end
    end
    req_valid[0]   = 1'b1;
    req_wr[0]      = 1'b1;
    req_addr[0]    = 32'h0000_0408;
    req_wr_data[0] = 32'hCAFE_F00D;
    step();
    checks++;
    if (bus_cs !== 1'b1 || grant_id !== 1'b0 || bus_addr !== 32'h0000_0408) begin
      errors++; $display("FAIL rst_next_issue: got cs=%b gid=%0d addr=%h want 1 0 00000408", bus_cs, grant_id, bus_addr);
    end
    step();
    checks++;
    if (req_ack !== 2'b01) begin
      errors++; $display("FAIL rst_next_ack: got %b want 01", req_ack);
    end
    req_valid[0] = 1'b0;
    step();
  endtask

  task automatic test_rd_latency0();
    r0_bus_rd_data  = 32'hBAD0_BAD0;
    r0_req_valid[0] = 1'b1;
    r0_req_wr[0]    = 1'b0;
    r0_req_addr[0]  = 32'h0000_0500;
    step();
    r0_bus_rd_data = 32'h0BAD_F00D;
    checks++;
    if ({r0_bus_cs, r0_bus_wr, r0_bus_rd} !== 3'b101 || r0_bus_addr !== 32'h0000_0500) begin
      errors++; $display("FAIL lat0_issue: got strobes=%b addr=%h want 101 00000500",
                         {r0_bus_cs, r0_bus_wr, r0_bus_rd}, r0_bus_addr);
    end
    step();
    r0_bus_rd_data = 32'hBAD0_BAD0;
    checks++;
    if (r0_req_ack !== 2'b01 || r0_rsp_rd_data !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL lat0_done: got ack=%b data=%h want 01 0badf00d", r0_req_ack, r0_rsp_rd_data);
    end
    r0_req_valid[0] = 1'b0;
    step();
    checks++;
    if (r0_req_ack !== 2'b00 || r0_busy !== 1'b0) begin
      errors++; $display("FAIL lat0_idle: got ack=%b busy=%b want 00 0", r0_req_ack, r0_busy);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    req_valid      = '0;
    req_wr         = '0;
    req_addr       = '0;
    req_wr_data    = '0;
    bus_rd_data    = 32'hBAD0_BAD0;
    r0_req_valid   = '0;
    r0_req_wr      = '0;
    r0_req_addr    = '0;
    r0_req_wr_data = '0;
    r0_bus_rd_data = 32'hBAD0_BAD0;

    test_reset();
    test_single_write();
    test_read_lat1();
    test_contention();
    test_late_arrival();
    test_reset_in_wait();
    test_rd_latency0();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single MMIO I/O bus (the bus_cs/bus_wr/bus_rd/bus_addr/bus_wr_data/bus_rd_data interface into the slot decoder) between NUM_REQ bus masters, e.g. the CPU data port and a DMA engine.
- Uses round-robin arbitration and runs exactly one bus transaction per grant.
- Handles read-data latency and returns a per-requester acknowledge pulse with the read data.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- RD_LATENCY, 1, clock cycles from the read issue cycle until bus_rd_data is valid (0..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  [NUM_REQ-1:0]  request pending; held with its fields until req_ack.
- req_wr  in  [NUM_REQ-1:0]  1 = write, 0 = read.
- req_addr  in  [31:0] x NUM_REQ  byte address.
- req_wr_data  in  [31:0] x NUM_REQ  write data.
- req_ack  out  [NUM_REQ-1:0]  one-cycle completion pulse, one-hot.
- rsp_rd_data  out  32  read data; valid in the req_ack cycle.
- busy  out  1  FSM not in IDLE.
- grant_id  out  $clog2(NUM_REQ)  requester currently or last served.
- bus_cs  out  1  I/O bus chip select.
- bus_wr  out  1  bus write strobe.
- bus_rd  out  1  bus read strobe.
- bus_addr  out  32  bus address.
- bus_wr_data  out  32  bus write data.
- bus_rd_data  in  32  bus read data (combinational mux from the slots).

Behaviour:
- All outputs are registered or decoded from state registers.
- Reset values:
  - bus_cs, bus_wr, bus_rd = 0.
  - bus_addr, bus_wr_data, rsp_rd_data = 0.
  - req_ack = 0; busy = 0.
  - grant_id = NUM_REQ-1, so requester 0 wins first.
  - State = IDLE; wait counter = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from grant_id+1 upward with wrap.
  - Latch the winner's wr, addr and wr_data into the bus registers and its index into grant_id; go to ISSUE.
  - Otherwise stay in IDLE; bus strobes are 0 and bus_addr holds its last value.
- ISSUE (exactly 1 cycle):
  - bus_cs = 1; bus_wr = latched wr; bus_rd = !latched wr.
  - Write: go to DONE.
  - Read with RD_LATENCY = 0: capture bus_rd_data into rsp_rd_data; go to DONE.
  - Read with RD_LATENCY > 0: load the counter with RD_LATENCY-1; go to WAIT.
- WAIT:
  - bus_cs, bus_wr, bus_rd = 0; bus_addr is held stable so the read mux keeps its selection.
  - Counter decrements each cycle.
  - When the counter reaches 0: capture bus_rd_data into rsp_rd_data; go to DONE.
- DONE (1 cycle):
  - req_ack[grant_id] = 1; rsp_rd_data is valid (holds its previous value for writes); go to IDLE.
- Latency from request to ack (req_valid seen in IDLE, ack in DONE):
  - write: 2 cycles;
  - read: 2 + RD_LATENCY cycles.
- Throughput: 3 cycles per write back-to-back.
- Requester rules:
  - Hold req_valid and all fields stable until req_ack.
  - Drop req_valid, or present a new request, the cycle after ack.
  - Request fields are latched at grant; later changes are ignored until ack.
- Fairness: grant_id advances only on a grant. With all requesters asserted, grants rotate 0, 1, …, NUM_REQ-1, 0.
- Simultaneous events:
  - New requests arriving during ISSUE, WAIT or DONE are not sampled until IDLE.
  - A requester withdrawing req_valid before ack is a protocol violation; the transaction still completes and acks.
- Reset mid-transaction: abort immediately. Strobes drop in the next cycle, no ack is issued, and everything returns to the reset values.
- Exactly one bus_cs cycle per transaction; bus_wr and bus_rd are never both 1.

Decomposition:
- Package io_arb_pkg:
  - arb_state_t enum (IDLE, ISSUE, WAIT, DONE);
  - BUS_AW = 32, BUS_DW = 32;
  - max NUM_REQ constant.
- Sub-module rr_arbiter:
  - combinational rotating-priority picker;
  - inputs: req vector and last grant index;
  - outputs: any_req and next grant index;
  - unit-testable on its own.

Test Plan:
- Single write: req_valid[0]=1, wr=1, addr=0x0000_0184, data=0xDEAD_BEEF -> one-cycle ISSUE with bus_cs=1, bus_wr=1, bus_addr=0x184, bus_wr_data=0xDEADBEEF; req_ack[0] exactly 2 cycles after the request is sampled.
- Read, RD_LATENCY=1: req1 reads 0x200; the bench drives bus_rd_data=0x1234_5678 one cycle after ISSUE -> rsp_rd_data=0x12345678 with req_ack[1]; bus_addr stays 0x200 through WAIT.
- Contention: both requesters held continuously for 6 transactions -> grants 0,1,0,1,0,1; no two acks in the same cycle; no overlapping bus_cs.
- Late arrival: req1 asserts during req0's WAIT -> req1 is granted in the first IDLE after req0's DONE; req0's data is unaffected.
- Reset in WAIT: reset=1 for 1 cycle during a read -> no req_ack; all outputs return to their reset values; grant_id=NUM_REQ-1; the next request from req0 is served normally.
- RD_LATENCY=0 build: the read captures bus_rd_data in the ISSUE cycle; ack arrives 2 cycles after the request.
